// File: rtl/axi_mem_responder_if.sv
// AXI4 slave-side bus bundle for axi_mem_responder (AW/W/B/AR/R channels, INCR-only subset).
interface axi_mem_responder_if #(
  parameter int DW = 512,
  parameter int AW = 64
);
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [7:0]      S_AXI_AWLEN;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [7:0]      S_AXI_ARLEN;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RLAST;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 INCR-burst memory slave over a read-first dual-port RAM; independent read and write FSMs.
// Optional AXI_MEM_SLVERR_EN: bursts starting beyond the RAM size get SLVERR instead of aliasing.
module axi_mem_responder #(
  parameter int DW    = 512,
  parameter int AW    = 64,
  parameter int DEPTH = 1024
) (
  input logic                clk,
  input logic                reset,
  axi_mem_responder_if.slave s_axi
);
  localparam int unsigned STRB    = DW / 8;
  localparam int          IDX_LSB = $clog2(STRB);
  localparam int          IDX_W   = $clog2(DEPTH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [DW-1:0] ram_q [DEPTH];
  logic [DW-1:0] ram_rdata_q;

  w_state_e         w_state_q, w_state_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [7:0]       w_cnt_q, w_cnt_d;
  logic             w_err_q, w_err_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;

  r_state_e         r_state_q, r_state_d;
  logic [IDX_W-1:0] r_idx_q, r_idx_d;
  logic [8:0]       r_left_q, r_left_d;
  logic             r_err_q, r_err_d;
  logic             arready_q, arready_d;
  logic             pend_q, pend_d;
  logic             pend_last_q, pend_last_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [1:0]       out_resp_q, out_resp_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic             skid_last_q, skid_last_d;
  logic [1:0]       skid_resp_q, skid_resp_d;
  logic [DW-1:0]    skid_data_q, skid_data_d;

  logic          aw_hs, w_hs, b_hs, ram_we;
  logic          ar_hs, r_pop, rd_issue;
  logic [1:0]    occ;
  logic          aw_oob, ar_oob;
  logic [DW-1:0] in_data;
  logic [1:0]    in_resp;

`ifdef AXI_MEM_SLVERR_EN
  assign aw_oob = |s_axi.S_AXI_AWADDR[AW-1:IDX_LSB+IDX_W];
  assign ar_oob = |s_axi.S_AXI_ARADDR[AW-1:IDX_LSB+IDX_W];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi.S_AXI_AWADDR[IDX_LSB-1:0], s_axi.S_AXI_ARADDR[IDX_LSB-1:0]};
`else
  assign aw_oob = 1'b0;
  assign ar_oob = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi.S_AXI_AWADDR[IDX_LSB-1:0], s_axi.S_AXI_AWADDR[AW-1:IDX_LSB+IDX_W],
                              s_axi.S_AXI_ARADDR[IDX_LSB-1:0], s_axi.S_AXI_ARADDR[AW-1:IDX_LSB+IDX_W]};
`endif

  assign aw_hs  = s_axi.S_AXI_AWVALID & awready_q;
  assign w_hs   = s_axi.S_AXI_WVALID & wready_q;
  assign b_hs   = bvalid_q & s_axi.S_AXI_BREADY;
  assign ram_we = w_hs & ~w_err_q;

  assign ar_hs  = s_axi.S_AXI_ARVALID & arready_q;
  assign r_pop  = out_valid_q & s_axi.S_AXI_RREADY;
  // Slots taken after this cycle: output reg, skid reg and the RAM read in flight.
  assign occ      = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(pend_q) - 2'(r_pop);
  assign rd_issue = (r_state_q == R_DATA) && (r_left_q != 9'd0) && (occ < 2'd2);
  assign in_data  = r_err_q ? '0 : ram_rdata_q;
  assign in_resp  = r_err_q ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int unsigned b = 0; b < STRB; b++) begin
        if (s_axi.S_AXI_WSTRB[b]) ram_q[w_idx_q][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
      end
    end
    if (rd_issue) ram_rdata_q <= ram_q[r_idx_q];
  end

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          w_idx_d   = s_axi.S_AXI_AWADDR[IDX_LSB +: IDX_W];
          w_cnt_d   = s_axi.S_AXI_AWLEN;
          w_err_d   = aw_oob;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          w_idx_d = w_idx_q + IDX_W'(1);
          if (w_cnt_q == 8'd0) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_err_q ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end else begin
            w_cnt_d = w_cnt_q - 8'd1;
          end
        end
      end
      W_RESP: begin
        if (b_hs) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d    = r_state_q;
    r_idx_d      = r_idx_q;
    r_left_d     = r_left_q;
    r_err_d      = r_err_q;
    arready_d    = arready_q;
    pend_d       = rd_issue;
    pend_last_d  = rd_issue && (r_left_q == 9'd1);
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_resp_d   = out_resp_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    skid_resp_d  = skid_resp_q;
    skid_data_d  = skid_data_q;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          r_idx_d   = s_axi.S_AXI_ARADDR[IDX_LSB +: IDX_W];
          r_left_d  = {1'b0, s_axi.S_AXI_ARLEN} + 9'd1;
          r_err_d   = ar_oob;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rd_issue) begin
          r_idx_d  = r_idx_q + IDX_W'(1);
          r_left_d = r_left_q - 9'd1;
        end
        if (r_pop && out_last_q) begin
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
    endcase
    // Output register refills from the skid entry first so beat order is preserved.
    if (!out_valid_q || r_pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_last_d   = skid_last_q;
        out_resp_d   = skid_resp_q;
        out_data_d   = skid_data_q;
        skid_valid_d = pend_q;
        skid_last_d  = pend_last_q;
        skid_resp_d  = in_resp;
        skid_data_d  = in_data;
      end else begin
        out_valid_d = pend_q;
        out_last_d  = pend_q & pend_last_q;
        out_resp_d  = pend_q ? in_resp : RESP_OKAY;
        out_data_d  = in_data;
      end
    end else if (pend_q) begin
      skid_valid_d = 1'b1;
      skid_last_d  = pend_last_q;
      skid_resp_d  = in_resp;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q    <= W_IDLE;
      w_idx_q      <= '0;
      w_cnt_q      <= '0;
      w_err_q      <= 1'b0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      r_state_q    <= R_IDLE;
      r_idx_q      <= '0;
      r_left_q     <= '0;
      r_err_q      <= 1'b0;
      arready_q    <= 1'b0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_resp_q   <= RESP_OKAY;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_resp_q  <= RESP_OKAY;
      skid_data_q  <= '0;
    end else begin
      w_state_q    <= w_state_d;
      w_idx_q      <= w_idx_d;
      w_cnt_q      <= w_cnt_d;
      w_err_q      <= w_err_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      r_state_q    <= r_state_d;
      r_idx_q      <= r_idx_d;
      r_left_q     <= r_left_d;
      r_err_q      <= r_err_d;
      arready_q    <= arready_d;
      pend_q       <= pend_d;
      pend_last_q  <= pend_last_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_resp_q   <= out_resp_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      skid_resp_q  <= skid_resp_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = out_valid_q;
  assign s_axi.S_AXI_RDATA   = out_data_q;
  assign s_axi.S_AXI_RLAST   = out_last_q;
  assign s_axi.S_AXI_RRESP   = out_resp_q;
endmodule
